// File: rtl/bx_paged_mem_pkg.sv
// +----------------------------------------------------------------------+
// | bx_paged_mem_pkg : shared defaults and helpers for the paged BX store |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package bx_paged_mem_pkg;

  localparam int DEF_DATA_WIDTH = 18;
  localparam int DEF_ADDR_BITS  = 6;
  localparam int DEF_PAGE_BITS  = 3;
  localparam int DEF_DONE_DELAY = 4;

  // A count must reach 2**addr_bits (a full page), hence one extra bit.
  function automatic int count_width(input int addr_bits);
    return addr_bits + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bx_paged_mem_sdp_ram.sv
// +----------------------------------------------------------------------+
// | sdp_ram : simple dual-port RAM, read-first, reset registered output   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sdp_ram
  import bx_paged_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_PAGE_BITS + DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/bx_paged_mem.sv
// +----------------------------------------------------------------------+
// | bx_paged_mem : per-BX paged entry store with counts and drop flags    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module bx_paged_mem
  import bx_paged_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int PAGE_BITS  = DEF_PAGE_BITS,
  parameter int DONE_DELAY = DEF_DONE_DELAY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [1:0]                     start,
  output logic [1:0]                     done,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           wr_valid,
  input  logic [PAGE_BITS+ADDR_BITS-1:0] read_add,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [ADDR_BITS:0]             number_out,
  output logic [2**PAGE_BITS-1:0]        overflow
);

  localparam int NUM_PAGES = 2**PAGE_BITS;
  localparam int CNT_W     = count_width(ADDR_BITS);
  localparam int RAM_AW    = PAGE_BITS + ADDR_BITS;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2**ADDR_BITS);

  logic [PAGE_BITS-1:0]  wr_page;
  logic [CNT_W-1:0]      count [NUM_PAGES];
  logic                  wp_en;
  logic [RAM_AW-1:0]     wp_addr;
  logic [DATA_WIDTH-1:0] wp_data;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [1:0]            dly [DONE_DELAY];

  logic [PAGE_BITS-1:0]  page_n;
  logic [CNT_W-1:0]      cnt_cur;
  logic                  has_room;

  // A write coinciding with a new-BX strobe targets the fresh, empty page.
  always_comb begin
    page_n  = wr_page;
    cnt_cur = count[wr_page];
    if (start[0]) begin
      page_n  = wr_page + PAGE_BITS'(1);
      cnt_cur = '0;
    end
    has_room = (cnt_cur < CNT_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_page  <= '1;
      overflow <= '0;
      wp_en    <= 1'b0;
      wp_addr  <= '0;
      wp_data  <= '0;
      for (int i = 0; i < NUM_PAGES; i++) count[i] <= '0;
    end else begin
      wp_en <= 1'b0;
      if (start[1]) begin
        wr_page  <= '1;
        overflow <= '0;
        for (int i = 0; i < NUM_PAGES; i++) count[i] <= '0;
      end else begin
        if (start[0]) begin
          wr_page          <= page_n;
          count[page_n]    <= '0;
          overflow[page_n] <= 1'b0;
        end
        if (wr_valid) begin
          if (has_room) begin
            wp_en         <= 1'b1;
            wp_addr       <= {page_n, cnt_cur[ADDR_BITS-1:0]};
            wp_data       <= data_in;
            count[page_n] <= cnt_cur + 1'b1;
          end else begin
            overflow[page_n] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      number_out <= '0;
      for (int i = 0; i < DONE_DELAY; i++) dly[i] <= '0;
    end else begin
      data_out   <= rd_q;
      number_out <= count[read_add[RAM_AW-1 -: PAGE_BITS]];
      dly[0]     <= start;
      for (int i = 1; i < DONE_DELAY; i++) dly[i] <= dly[i-1];
    end
  end

  assign done = dly[DONE_DELAY-1];

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wp_en),
    .wr_addr (wp_addr),
    .wr_data (wp_data),
    .rd_addr (read_add),
    .rd_data (rd_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_bx_paged_mem.sv
// +----------------------------------------------------------------------+
// | tb_bx_paged_mem : scenario bench for bx_paged_mem at default sizes    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bx_paged_mem;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [1:0]  done;
  logic [17:0] data_in = '0;
  logic        wr_valid = 1'b0;
  logic [8:0]  read_add = '0;
  logic [17:0] data_out;
  logic [6:0]  number_out;
  logic [7:0]  overflow;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  bx_paged_mem #(
    .DATA_WIDTH (18),
    .ADDR_BITS  (6),
    .PAGE_BITS  (3),
    .DONE_DELAY (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .data_in    (data_in),
    .wr_valid   (wr_valid),
    .read_add   (read_add),
    .data_out   (data_out),
    .number_out (number_out),
    .overflow   (overflow)
  );

  // One clock with the given inputs; returns 1 ns after the edge.
  task automatic step(input logic [1:0] st, input logic wv, input logic [17:0] d);
    start    = st;
    wr_valid = wv;
    data_in  = d;
    @(posedge clk);
    #1;
    start    = 2'b00;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [8:0] a, input logic [6:0] exp_n,
                         input logic [17:0] exp_d, input logic chk_d, input string tag);
    logic [17:0] want;
    read_add = a;
    if (chk_d) exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    checks++;
    if (number_out !== exp_n) begin
      errors++;
      $display("FAIL %s number_out: got %0d expected %0d", tag, number_out, exp_n);
    end
    @(posedge clk);
    #1;
    if (chk_d) begin
      want = exp_q.pop_front();
      checks++;
      if (data_out !== want) begin
        errors++;
        $display("FAIL %s data_out: got %0h expected %0h", tag, data_out, want);
      end
    end
  endtask

  task automatic chk_ovf(input logic [7:0] exp, input string tag);
    checks++;
    if (overflow !== exp) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b", tag, overflow, exp);
    end
  endtask

  task automatic chk_done(input logic [1:0] exp, input string tag);
    checks++;
    if (done !== exp) begin
      errors++;
      $display("FAIL %s done: got %b expected %b", tag, done, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (data_out !== 18'h0) begin errors++; $display("FAIL reset data_out: got %0h expected 0", data_out); end
    if (number_out !== 7'h0) begin errors++; $display("FAIL reset number_out: got %0d expected 0", number_out); end
    if (done !== 2'b00) begin errors++; $display("FAIL reset done: got %b expected 00", done); end
    chk_ovf(8'h00, "reset");
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    step(2'b01, 1'b0, 18'h0);
    step(2'b00, 1'b1, 18'h1);
    step(2'b00, 1'b1, 18'h2);
    step(2'b00, 1'b1, 18'h3);
    step(2'b00, 1'b0, 18'h0);
    do_read(9'h000, 7'd3, 18'h1, 1'b1, "basic_e0");
    do_read(9'h001, 7'd3, 18'h2, 1'b1, "basic_e1");
    do_read(9'h002, 7'd3, 18'h3, 1'b1, "basic_e2");
    chk_ovf(8'h00, "basic");
  endtask

  task automatic test_overflow();
    step(2'b10, 1'b0, 18'h0);
    step(2'b01, 1'b0, 18'h0);
    for (int i = 0; i < 70; i++) begin
      step(2'b00, 1'b1, 18'(32'h100 + i));
      if (i == 63) chk_ovf(8'h00, "ovf_at_full");
    end
    step(2'b00, 1'b0, 18'h0);
    chk_ovf(8'h01, "ovf_after_drop");
    do_read(9'h03F, 7'd64, 18'h13F, 1'b1, "ovf_last");
    do_read(9'h000, 7'd64, 18'h100, 1'b1, "ovf_first");
    step(2'b01, 1'b0, 18'h0);
    chk_ovf(8'h01, "ovf_next_page");
    step(2'b00, 1'b1, 18'h55);
    step(2'b00, 1'b0, 18'h0);
    do_read(9'h040, 7'd1, 18'h55, 1'b1, "ovf_page1");
  endtask

  task automatic test_wrap();
    for (int p = 2; p < 8; p++) step(2'b01, 1'b1, 18'(32'h300 + p));
    chk_ovf(8'h01, "wrap_before");
    step(2'b01, 1'b0, 18'h0);
    chk_ovf(8'h00, "wrap_cleared");
    step(2'b00, 1'b1, 18'h2AA);
    do_read(9'h000, 7'd1, 18'h100, 1'b1, "wrap_read_first");
    do_read(9'h000, 7'd1, 18'h2AA, 1'b1, "wrap_new");
    do_read(9'h040, 7'd1, 18'h55, 1'b1, "wrap_page1_kept");
    do_read(9'h0C0, 7'd1, 18'h303, 1'b1, "wrap_page3");
  endtask

  task automatic test_same_cycle();
    step(2'b01, 1'b1, 18'hAB);
    step(2'b00, 1'b0, 18'h0);
    do_read(9'h040, 7'd1, 18'hAB, 1'b1, "same_cycle");
    chk_done(2'b01, "done_bit0");
  endtask

  task automatic test_clear();
    step(2'b00, 1'b1, 18'h11);
    step(2'b10, 1'b1, 18'h22);
    do_read(9'h040, 7'd0, 18'h0, 1'b0, "clear_page1");
    chk_done(2'b00, "clear_done_early");
    step(2'b00, 1'b0, 18'h0);
    chk_done(2'b10, "clear_done");
    do_read(9'h000, 7'd0, 18'h0, 1'b0, "clear_page0");
    step(2'b01, 1'b1, 18'h77);
    step(2'b00, 1'b0, 18'h0);
    do_read(9'h000, 7'd1, 18'h77, 1'b1, "clear_restart");
  endtask

  task automatic test_async_reset();
    step(2'b01, 1'b0, 18'h0);
    step(2'b00, 1'b1, 18'h5);
    #3;
    reset = 1'b0;
    #1;
    checks += 3;
    if (data_out !== 18'h0) begin errors++; $display("FAIL async data_out: got %0h expected 0", data_out); end
    if (number_out !== 7'h0) begin errors++; $display("FAIL async number_out: got %0d expected 0", number_out); end
    if (done !== 2'b00) begin errors++; $display("FAIL async done: got %b expected 00", done); end
    chk_ovf(8'h00, "async");
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_same_cycle();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bx_paged_mem.md
BX_PAGED_MEM -- requirements
Module: bx_paged_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 18: width of a stored entry.
REQ-002 Parameter ADDR_BITS, default 6: log2 of entries per BX page (64).
REQ-003 Parameter PAGE_BITS, default 3: log2 of resident BX pages (8).
REQ-004 Parameter DONE_DELAY, default 4: cycles from start to done.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  2  bit0 = new-BX strobe; bit1 = synchronous pipeline clear.
REQ-008 done  out  2  start delayed by DONE_DELAY cycles.
REQ-009 data_in  in  DATA_WIDTH  entry to store.
REQ-010 wr_valid  in  1  data_in is valid this cycle.
REQ-011 read_add  in  PAGE_BITS+ADDR_BITS  {page, entry} read address.
REQ-012 data_out  out  DATA_WIDTH  read data.
REQ-013 number_out  out  ADDR_BITS+1  entry count of page read_add[top PAGE_BITS].
REQ-014 overflow  out  2**PAGE_BITS  per-page sticky drop flag.

Function
REQ-015 The write page pointer wr_page (PAGE_BITS) SHALL increment modulo 2**PAGE_BITS on every cycle start[0]=1 and start[1]=0.
REQ-016 On that advance, count[new page] and overflow[new page] SHALL clear in the same edge; other pages keep their values.
REQ-017 start[1]=1 SHALL set wr_page to all ones, clear every count and overflow bit, and take precedence over start[0] and wr_valid.
REQ-018 With wr_valid=1 and count[wr_page] < 2**ADDR_BITS, data_in SHALL be written at {wr_page, count[wr_page]} and count SHALL increment by 1.
REQ-019 Write uses a one-cycle registered path: data, address and enable are registered, and the RAM write occurs one edge after capture.
REQ-020 With wr_valid=1 and count[wr_page] = 2**ADDR_BITS, data SHALL be dropped, count SHALL hold, and overflow[wr_page] SHALL set.
REQ-021 With start[0] and wr_valid both 1 in the same cycle, the entry SHALL go to the new page at entry 0, and the new count SHALL be 1.
REQ-022 data_out SHALL present RAM[read_add] two cycles after read_add is applied (RAM read register plus output register).
REQ-023 A read of the address being written in the same cycle SHALL return the old contents (read-first).
REQ-024 number_out SHALL be registered, with one-cycle latency from read_add.
REQ-025 number_out SHALL reflect the count after all updates of the prior edge.
REQ-026 done SHALL equal start from DONE_DELAY cycles earlier, bit for bit; start[1] does not clear the delay line.

Reset
REQ-027 While reset=0, the following SHALL hold:
- wr_page = all ones
- every count = 0, every overflow bit = 0
- done = 0, data_out = 0, number_out = 0
- write pipeline enable = 0; delay line = 0
REQ-028 RAM contents are not reset.
REQ-029 Reset deassertion mid-BX SHALL restart cleanly: the first start[0] selects page 0.

Structure
REQ-030 A shared package SHALL hold the default parameter constants and a function computing the count width (ADDR_BITS+1).
REQ-031 Storage SHALL be one sub-module, sdp_ram, with the following properties:
- simple dual-port, depth 2**(PAGE_BITS+ADDR_BITS)
- registered output
- output reset tied to reset
REQ-032 Counts and overflow SHALL be flop arrays inside bx_paged_mem; the done delay is an internal shift register.

Verification
REQ-033 Reset, start[0], then 3 wr_valid pulses with data 0x1,0x2,0x3 -> page 0 entries 0..2 hold 1,2,3; number_out(read page 0) = 3; data_out for read_add 0x002 = 0x3 two cycles later.
REQ-034 Write 70 entries in one BX at defaults -> count = 64, overflow[0] = 1, entries 64-69 dropped; next start[0] -> page 1, overflow[1] = 0, overflow[0] still 1.
REQ-035 Issue 9 start[0] strobes with 1 write each -> page 0 is overwritten by the 9th BX: count[0] = 1, overflow[0] = 0, data at 0x000 = new value.
REQ-036 start[0] and wr_valid together with data 0xAB -> entry lands at {new page, 0}; count = 1.
REQ-037 start[1] asserted during writes -> all counts = 0 next cycle; following start[0] -> page 0; done still shows start[1] after 4 cycles.
REQ-038 Assert reset low asynchronously mid-burst -> outputs zero without a clock edge; post-release behaviour matches REQ-033.
